rvc_fetch_aligner: RTL

Halfword fetch aligner between the instruction-memory port and the RVC decoder. It issues word-aligned 32-bit fetches and buffers up to three halfwords. It presents one instruction per handshake, with its PC and a compressed flag, so 16-bit and 32-bit instructions at any halfword boundary reach decode, including 32-bit instructions that span two fetch words. It also handles control-flow redirects by flushing the buffer and discarding any in-flight fetch.

---
 rtl/rvc_fetch_aligner.sv | 99 +++++++++
 1 files changed

// File: rtl/rvc_fetch_aligner.sv
// rvc_fetch_aligner: word fetcher plus 3-halfword buffer that presents aligned 16/32-bit RVC instructions.
module rvc_fetch_aligner #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_data_i,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic [31:0] instr_o,
   output logic [31:0] instr_pc_o,
   output logic        is_compressed_o
);
   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;
   state_e            state_q, state_d;
   logic [1:0]        count_q, count_d, c_pop;
   logic [2:0][15:0]  hw_q, hw_d;
   logic [31:0]       pc_q, pc_d, fetch_q, fetch_d, req_addr_q, req_addr_d;
   logic              skip_q, skip_d;
   logic              head_c, pop, ack_keep;
   assign head_c          = hw_q[0][1:0] != 2'b11;
   assign instr_valid_o   = !redirect_i && (head_c ? count_q != 2'd0 : count_q >= 2'd2);
   assign pop             = instr_valid_o && instr_ready_i;
   assign ack_keep        = state_q == WAIT && imem_ack_i && !redirect_i;
   assign imem_req_o      = state_q != IDLE;
   // the live request keeps its own address so a redirect cannot disturb it
   assign imem_addr_o     = imem_req_o ? req_addr_q : fetch_q;
   assign instr_o         = head_c ? {16'h0, hw_q[0]} : {hw_q[1], hw_q[0]};
   assign instr_pc_o      = pc_q;
   assign is_compressed_o = head_c && count_q != 2'd0;
   always_comb begin
      hw_d    = hw_q;
      c_pop   = count_q;
      pc_d    = pc_q;
      fetch_d = fetch_q;
      skip_d  = skip_q;
      if (pop) begin
         c_pop   = count_q - (head_c ? 2'd1 : 2'd2);
         pc_d    = pc_q + (head_c ? 32'd2 : 32'd4);
         hw_d[0] = head_c ? hw_q[1] : hw_q[2];
         hw_d[1] = hw_q[2];
      end
      count_d = c_pop;
      if (ack_keep) begin
         for (int i = 0; i < 3; i++) begin
            if (skip_q ? c_pop == 2'(i) : c_pop + 2'd1 == 2'(i))
               hw_d[i] = imem_data_i[31:16];
            else if (!skip_q && c_pop == 2'(i))
               hw_d[i] = imem_data_i[15:0];
         end
         count_d = c_pop + (skip_q ? 2'd1 : 2'd2);
         fetch_d = fetch_q + 32'd4;
         skip_d  = 1'b0;
      end
      if (redirect_i) begin
         count_d = 2'd0;
         pc_d    = redirect_pc_i & ~32'd1;
         fetch_d = redirect_pc_i & ~32'd3;
         skip_d  = redirect_pc_i[1];
      end
   end
   always_comb begin
      state_d    = state_q;
      req_addr_d = req_addr_q;
      case (state_q)
         IDLE: if (!redirect_i && count_d <= 2'd1) begin
            state_d    = WAIT;
            req_addr_d = fetch_q;
         end
         WAIT: state_d = imem_ack_i ? IDLE : redirect_i ? DROP : WAIT;
         DROP: state_d = imem_ack_i ? IDLE : DROP;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= IDLE;
         count_q    <= 2'd0;
         hw_q       <= '0;
         pc_q       <= RESET_PC & ~32'd1;
         fetch_q    <= RESET_PC & ~32'd3;
         req_addr_q <= RESET_PC & ~32'd3;
         skip_q     <= RESET_PC[1];
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         hw_q       <= hw_d;
         pc_q       <= pc_d;
         fetch_q    <= fetch_d;
         req_addr_q <= req_addr_d;
         skip_q     <= skip_d;
      end
   end
endmodule
